cnn_layer_scheduler: RTL and testbench
======================================

Name: cnn_layer_scheduler

Overview:
- Top-level sequencer and shared-memory arbiter for the three-layer CNN pipeline: Layer0 (conv), Layer1 (max-pool) and Layer2 (flatten).
- Launches the layers in order, one at a time. Grants the single shared memory port (crd/cwr/csel/caddr_rd/caddr_wr/cdata_wr) to the active layer only.
- Reports busy/done to the host. Flags protocol violations and hung layers.

Parameters:
- AW, 12, memory address width
- DW, 20, memory data width
- TIMEOUT_CYC, 8192, maximum cycles any single layer may stay active before a timeout error

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- ready  in  1  host start request
- busy  out  1  high from the first cycle of layer 0 until done/error
- done  out  1  one-cycle pulse after Finish2
- err_timeout  out  1  sticky; a layer exceeded TIMEOUT_CYC
- err_viol  out  1  sticky; a non-granted layer drove crd/cwr, or the granted layer drove crd and cwr together
- start0/start1/start2  out  1 each  one-cycle launch pulse to each layer
- Finish0/Finish1/Finish2  in  1 each  layer-complete indications
- crdN, cwrN  in  1 each (N=0..2)  per-layer read/write strobes
- cselN  in  3 each  per-layer memory select
- caddr_rdN, caddr_wrN  in  AW each  per-layer addresses
- cdata_wrN  in  DW each  per-layer write data
- crd, cwr  out  1  shared-port strobes
- csel  out  3  shared-port select
- caddr_rd, caddr_wr  out  AW  shared-port addresses
- cdata_wr  out  DW  shared-port write data

Behaviour:
- Reset (synchronous, active-high; takes effect at the next clk edge, including mid-layer): state=IDLE, wdog=0.
  - busy, done, start0-2, err_timeout, err_viol all 0.
  - Shared port outputs all 0.
- FSM states: IDLE, L0, L1, L2, DONE, ERR. Registered state; all control outputs decoded from state or registered.
- IDLE:
  - ready=1 -> L0.
  - start0 is high for exactly the first cycle in L0. Same rule for start1 in L1 and start2 in L2.
- L0: Finish0=1 -> L1.
- L1: Finish1=1 -> L2.
- L2: Finish2=1 -> DONE.
- DONE: done=1 for one cycle, then IDLE unconditionally.
- Finish from a non-active layer: ignored, no state change, no error.
- ready while not IDLE: ignored.
- busy=1 in L0/L1/L2. busy=0 in IDLE, DONE and ERR.
- Grant and mux:
  - Combinational (zero-latency) mux of the active layer's csel/caddr_rd/caddr_wr/cdata_wr/crd/cwr onto the shared port. The layers see cdata_rd exactly as if directly connected.
  - In IDLE, DONE and ERR all shared outputs are 0.
- Violations:
  - Non-granted layer asserts crd or cwr: the request is not forwarded; err_viol set next cycle.
  - Granted layer asserts crd and cwr in the same cycle: cwr is forwarded, crd is forced 0; err_viol set next cycle.
  - Violations do not change FSM state.
- Watchdog:
  - wdog clears on every state change. It increments each cycle in L0/L1/L2 and saturates.
  - If wdog reaches TIMEOUT_CYC-1 while still in the same layer state with no Finish that cycle -> ERR.
  - Finish in that same cycle wins (normal advance).
- ERR:
  - err_timeout=1; shared port idles at 0.
  - Leaves only on ready=1 -> L0 (fresh run). On that transition err_timeout and err_viol both clear.
- Clearing of sticky errors: err_viol and err_timeout clear only on reset or on the IDLE/ERR -> L0 transition.
- Layer-transition latency: Finish at cycle t -> new state and start pulse at cycle t+1.
  - The finishing layer loses the grant at t+1. Its strobes at t+1 and after are violations.

Test Plan:
- Normal run: reset 2 cycles, ready pulse at t=5. Expect:
  - start0 at t=6, busy=1 from t=6.
  - Finish0 at t=20 -> start1 at t=21.
  - Finish1 at t=40 -> start2 at t=41.
  - Finish2 at t=60 -> done=1 and busy=0 at t=61, IDLE at t=62.
- Mux check: in L1 drive csel1=4, caddr_rd1=0x123, crd1=1 and layer0/2 strobes 0. Shared csel=4, caddr_rd=0x123, crd=1 in the same cycle; err_viol stays 0.
- Violations:
  - In L2 drive cwr0=1 for one cycle: shared cwr=0 unless cwr2=1; err_viol=1 next cycle and stays set.
  - Then drive crd2=cwr2=1: shared crd=0, cwr=1.
- Timeout: TIMEOUT_CYC=16, ready, never assert Finish0. ERR reached 16 cycles after entering L0; err_timeout=1, busy=0, shared port 0. Then ready -> start0 next cycle, both errors clear.
- Spurious inputs: in L0 pulse Finish2 and ready. No state change, no start pulses, no error.
- Mid-run reset: assert reset in L1 with crd1=1. Next edge: state IDLE, crd=0, busy=0, start pulses 0, errors 0.

Source files
------------

// File: rtl/cnn_layer_scheduler_if.sv
// Bundle of host control, per-layer memory requests and the shared memory port.
// Latency: none; this is wiring only.
// Backpressure: none; the layers own their strobes and the shared port has no stall.
interface cnn_layer_scheduler_if #(
   parameter int AW = 12,
   parameter int DW = 20
);
   // host side
   logic          ready;
   logic          busy;
   logic          done;
   logic          err_timeout;
   logic          err_viol;

   // layer launch / completion
   logic          start0, start1, start2;
   logic          Finish0, Finish1, Finish2;

   // per-layer memory requests
   logic          crd0, crd1, crd2;
   logic          cwr0, cwr1, cwr2;
   logic [2:0]    csel0, csel1, csel2;
   logic [AW-1:0] caddr_rd0, caddr_rd1, caddr_rd2;
   logic [AW-1:0] caddr_wr0, caddr_wr1, caddr_wr2;
   logic [DW-1:0] cdata_wr0, cdata_wr1, cdata_wr2;

   // shared memory port
   logic          crd;
   logic          cwr;
   logic [2:0]    csel;
   logic [AW-1:0] caddr_rd;
   logic [AW-1:0] caddr_wr;
   logic [DW-1:0] cdata_wr;

   // scheduler side
   modport master (
      input  ready, Finish0, Finish1, Finish2,
      input  crd0, crd1, crd2, cwr0, cwr1, cwr2,
      input  csel0, csel1, csel2,
      input  caddr_rd0, caddr_rd1, caddr_rd2,
      input  caddr_wr0, caddr_wr1, caddr_wr2,
      input  cdata_wr0, cdata_wr1, cdata_wr2,
      output busy, done, err_timeout, err_viol,
      output start0, start1, start2,
      output crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr
   );

   // host / layer / memory side
   modport slave (
      output ready, Finish0, Finish1, Finish2,
      output crd0, crd1, crd2, cwr0, cwr1, cwr2,
      output csel0, csel1, csel2,
      output caddr_rd0, caddr_rd1, caddr_rd2,
      output caddr_wr0, caddr_wr1, caddr_wr2,
      output cdata_wr0, cdata_wr1, cdata_wr2,
      input  busy, done, err_timeout, err_viol,
      input  start0, start1, start2,
      input  crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr
   );
endinterface

// File: rtl/cnn_layer_scheduler.sv
// Sequences conv -> pool -> flatten layers and grants them the single shared memory port.
// Latency: Finish at cycle t gives new state/start pulse at t+1; memory mux is combinational.
// Backpressure: none; illegal strobes are dropped and flagged, hung layers are cut off by a watchdog.
module cnn_layer_scheduler #(
   parameter int AW          = 12,
   parameter int DW          = 20,
   parameter int TIMEOUT_CYC = 8192
) (
   input logic                   clk,
   input logic                   reset,
   cnn_layer_scheduler_if.master bus
);

   // Wide enough to hold TIMEOUT_CYC-1, also for TIMEOUT_CYC of 1.
   localparam int             WDW     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L0   = 3'd1,
      L1   = 3'd2,
      L2   = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   state_t         state, state_nxt;
   logic [WDW-1:0] wdog;
   logic [2:0]     grant;
   logic [2:0]     rd_v, wr_v;
   logic           timeout_hit;
   logic           launch;
   logic           viol;
   logic           err_timeout_q;
   logic           err_viol_q;

   logic [2:0]     m_csel;
   logic [AW-1:0]  m_addr_rd;
   logic [AW-1:0]  m_addr_wr;
   logic [DW-1:0]  m_data_wr;

   assign rd_v = {bus.crd2, bus.crd1, bus.crd0};
   assign wr_v = {bus.cwr2, bus.cwr1, bus.cwr0};

   // One-hot grant decoded from the registered state; nobody owns the port outside L0-L2.
   always_comb begin
      grant = 3'b000;
      case (state)
         L0:      grant = 3'b001;
         L1:      grant = 3'b010;
         L2:      grant = 3'b100;
         default: grant = 3'b000;
      endcase
   end

   // The watchdog sits at its last value only when the layer has used its full budget.
   assign timeout_hit = (wdog == WD_LAST);

   // Next-state: Finish of the active layer beats a timeout in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.ready) state_nxt = L0;
         L0: begin
            if (bus.Finish0)      state_nxt = L1;
            else if (timeout_hit) state_nxt = ERR;
         end
         L1: begin
            if (bus.Finish1)      state_nxt = L2;
            else if (timeout_hit) state_nxt = ERR;
         end
         L2: begin
            if (bus.Finish2)      state_nxt = DONE;
            else if (timeout_hit) state_nxt = ERR;
         end
         DONE:    state_nxt = IDLE;
         ERR:     if (bus.ready) state_nxt = L0;
         default: state_nxt = IDLE;
      endcase
   end

   // A fresh run begins; this is the only non-reset point where sticky errors clear.
   assign launch = ((state == IDLE) || (state == ERR)) && (state_nxt == L0);

   // State register and per-state watchdog (zeroed on every state change).
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         wdog  <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            wdog <= '0;
         else if ((|grant) && (wdog != WD_LAST))
            wdog <= wdog + 1'b1;
      end
   end

   // Sticky error flags; the launch clear wins over a violation seen in the launch cycle.
   always_ff @(posedge clk) begin
      if (reset || launch) begin
         err_timeout_q <= 1'b0;
         err_viol_q    <= 1'b0;
      end else begin
         if (state_nxt == ERR) err_timeout_q <= 1'b1;
         if (viol)             err_viol_q    <= 1'b1;
      end
   end

   // Any strobe from a layer without the grant, or read+write together from the granted one.
   assign viol = (|(~grant & (rd_v | wr_v))) | (|(grant & rd_v & wr_v));

   // AND-OR mux of the granted layer onto the shared port; all zero when no grant.
   assign m_csel    = ({3{grant[0]}}  & bus.csel0)
                    | ({3{grant[1]}}  & bus.csel1)
                    | ({3{grant[2]}}  & bus.csel2);
   assign m_addr_rd = ({AW{grant[0]}} & bus.caddr_rd0)
                    | ({AW{grant[1]}} & bus.caddr_rd1)
                    | ({AW{grant[2]}} & bus.caddr_rd2);
   assign m_addr_wr = ({AW{grant[0]}} & bus.caddr_wr0)
                    | ({AW{grant[1]}} & bus.caddr_wr1)
                    | ({AW{grant[2]}} & bus.caddr_wr2);
   assign m_data_wr = ({DW{grant[0]}} & bus.cdata_wr0)
                    | ({DW{grant[1]}} & bus.cdata_wr1)
                    | ({DW{grant[2]}} & bus.cdata_wr2);

   assign bus.csel     = m_csel;
   assign bus.caddr_rd = m_addr_rd;
   assign bus.caddr_wr = m_addr_wr;
   assign bus.cdata_wr = m_data_wr;
   // Write takes priority when the granted layer drives both strobes.
   assign bus.cwr      = |(grant & wr_v);
   assign bus.crd      = |(grant & rd_v & ~wr_v);

   // A zero watchdog inside a layer state marks its first cycle.
   assign bus.start0      = grant[0] && (wdog == '0);
   assign bus.start1      = grant[1] && (wdog == '0);
   assign bus.start2      = grant[2] && (wdog == '0);
   assign bus.busy        = |grant;
   assign bus.done        = (state == DONE);
   assign bus.err_timeout = err_timeout_q;
   assign bus.err_viol    = err_viol_q;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Directed bench for the CNN layer scheduler with a pulse scoreboard.
// Latency: checks start/done pulses against the cycle they were predicted for.
// Backpressure: not applicable; a second instance with a short watchdog covers the timeout path.
module tb_cnn_layer_scheduler;

   localparam int AW = 12;
   localparam int DW = 20;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   cnn_layer_scheduler_if #(.AW(AW), .DW(DW)) a ();
   cnn_layer_scheduler_if #(.AW(AW), .DW(DW)) b ();

   cnn_layer_scheduler #(.AW(AW), .DW(DW), .TIMEOUT_CYC(8192)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (a)
   );

   cnn_layer_scheduler #(.AW(AW), .DW(DW), .TIMEOUT_CYC(16)) dut_to (
      .clk   (clk),
      .reset (reset),
      .bus   (b)
   );

   typedef struct {
      int kind;   // 0..2 = startN, 3 = done
      int cyc;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_ev;
   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, want, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic expect_ev(input int k, input int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic idle_inputs();
      a.ready = 0; a.Finish0 = 0; a.Finish1 = 0; a.Finish2 = 0;
      a.crd0 = 0; a.crd1 = 0; a.crd2 = 0; a.cwr0 = 0; a.cwr1 = 0; a.cwr2 = 0;
      a.csel0 = '0; a.csel1 = '0; a.csel2 = '0;
      a.caddr_rd0 = '0; a.caddr_rd1 = '0; a.caddr_rd2 = '0;
      a.caddr_wr0 = '0; a.caddr_wr1 = '0; a.caddr_wr2 = '0;
      a.cdata_wr0 = '0; a.cdata_wr1 = '0; a.cdata_wr2 = '0;
      b.ready = 0; b.Finish0 = 0; b.Finish1 = 0; b.Finish2 = 0;
      b.crd0 = 0; b.crd1 = 0; b.crd2 = 0; b.cwr0 = 0; b.cwr1 = 0; b.cwr2 = 0;
      b.csel0 = '0; b.csel1 = '0; b.csel2 = '0;
      b.caddr_rd0 = '0; b.caddr_rd1 = '0; b.caddr_rd2 = '0;
      b.caddr_wr0 = '0; b.caddr_wr1 = '0; b.caddr_wr2 = '0;
      b.cdata_wr0 = '0; b.cdata_wr1 = '0; b.cdata_wr2 = '0;
   endtask

   // Scoreboard: every start/done pulse on the main instance must match the next predicted event.
   always @(negedge clk) begin
      if (cyc > 0 && (a.start0 | a.start1 | a.start2 | a.done) === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 64'({a.done, a.start2, a.start1, a.start0}), 64'd0);
         end else begin
            mon_ev = exp_q.pop_front();
            chk("pulse_kind", 64'({a.done, a.start2, a.start1, a.start0}), 64'(4'b0001 << mon_ev.kind));
            chk("pulse_cycle", 64'(cyc), 64'(mon_ev.cyc));
         end
      end
   end

   initial begin
      reset = 1'b1;
      idle_inputs();

      // reset state
      tick();                                   // cyc 1
      settle();
      chk("rst_busy",  64'(a.busy), 64'd0);
      chk("rst_done",  64'(a.done), 64'd0);
      chk("rst_start", 64'({a.start2, a.start1, a.start0}), 64'd0);
      chk("rst_err",   64'({a.err_timeout, a.err_viol}), 64'd0);
      chk("rst_port",  64'({a.crd, a.cwr, a.csel, a.caddr_rd, a.caddr_wr, a.cdata_wr}), 64'd0);
      tick();                                   // cyc 2
      reset = 1'b0;

      // launch layer 0
      wait_to(5);
      a.ready = 1; expect_ev(0, 6);
      tick();                                   // cyc 6
      a.ready = 0;
      settle();
      chk("l0_busy", 64'(a.busy), 64'd1);

      // spurious Finish of inactive layers and ready while busy
      wait_to(8);
      a.Finish1 = 1; a.Finish2 = 1; a.ready = 1;
      tick();                                   // cyc 9
      a.Finish1 = 0; a.Finish2 = 0; a.ready = 0;
      settle();
      chk("spur_busy",  64'(a.busy), 64'd1);
      chk("spur_start", 64'({a.start2, a.start1, a.start0}), 64'd0);
      chk("spur_err",   64'({a.err_timeout, a.err_viol}), 64'd0);

      // layer 0 -> layer 1
      wait_to(20);
      a.Finish0 = 1; expect_ev(1, 21);
      tick();                                   // cyc 21
      a.Finish0 = 0;

      // shared-port mux in L1
      wait_to(25);
      a.csel1 = 3'd4; a.caddr_rd1 = 12'h123; a.caddr_wr1 = 12'h0AB; a.cdata_wr1 = 20'h5A5A5; a.crd1 = 1;
      a.csel0 = 3'd1; a.caddr_rd0 = 12'h777; a.csel2 = 3'd7; a.cdata_wr2 = 20'hFFFFF;
      settle();
      chk("mux_csel",    64'(a.csel), 64'd4);
      chk("mux_addr_rd", 64'(a.caddr_rd), 64'h123);
      chk("mux_addr_wr", 64'(a.caddr_wr), 64'h0AB);
      chk("mux_data_wr", 64'(a.cdata_wr), 64'h5A5A5);
      chk("mux_strobes", 64'({a.crd, a.cwr}), 64'b10);
      tick();                                   // cyc 26
      idle_inputs();
      settle();
      chk("mux_no_viol", 64'(a.err_viol), 64'd0);

      // layer 1 -> layer 2
      wait_to(40);
      a.Finish1 = 1; expect_ev(2, 41);
      tick();                                   // cyc 41
      a.Finish1 = 0;

      // write strobe from non-granted layer 0
      wait_to(45);
      a.cwr0 = 1;
      settle();
      chk("viol_cwr_blocked", 64'({a.crd, a.cwr}), 64'd0);
      chk("viol_not_yet",     64'(a.err_viol), 64'd0);
      tick();                                   // cyc 46
      a.cwr0 = 0;
      settle();
      chk("viol_set", 64'(a.err_viol), 64'd1);
      wait_to(48);
      settle();
      chk("viol_sticky", 64'(a.err_viol), 64'd1);

      // granted layer drives read and write together
      wait_to(50);
      a.crd2 = 1; a.cwr2 = 1; a.caddr_wr2 = 12'h456;
      settle();
      chk("rdwr_strobes", 64'({a.crd, a.cwr}), 64'b01);
      chk("rdwr_addr_wr", 64'(a.caddr_wr), 64'h456);
      tick();                                   // cyc 51
      idle_inputs();

      // layer 2 -> done -> idle
      wait_to(60);
      a.Finish2 = 1; expect_ev(3, 61);
      tick();                                   // cyc 61
      a.Finish2 = 0;
      settle();
      chk("done_pulse", 64'(a.done), 64'd1);
      chk("done_busy",  64'(a.busy), 64'd0);
      tick();                                   // cyc 62
      settle();
      chk("idle_done",      64'(a.done), 64'd0);
      chk("idle_busy",      64'(a.busy), 64'd0);
      chk("idle_viol_held", 64'(a.err_viol), 64'd1);

      // relaunch clears the sticky violation
      wait_to(65);
      a.ready = 1; expect_ev(0, 66);
      tick();                                   // cyc 66
      a.ready = 0;
      settle();
      chk("relaunch_viol_clr", 64'(a.err_viol), 64'd0);
      chk("relaunch_busy",     64'(a.busy), 64'd1);
      wait_to(70);
      a.Finish0 = 1; expect_ev(1, 71);
      tick();                                   // cyc 71
      a.Finish0 = 0;

      // mid-run reset in L1 with a read in flight
      wait_to(75);
      a.crd1 = 1; reset = 1'b1;
      settle();
      chk("prerst_crd", 64'(a.crd), 64'd1);
      tick();                                   // cyc 76
      settle();
      chk("midrst_crd",   64'(a.crd), 64'd0);
      chk("midrst_busy",  64'(a.busy), 64'd0);
      chk("midrst_start", 64'({a.start2, a.start1, a.start0}), 64'd0);
      chk("midrst_err",   64'({a.err_timeout, a.err_viol}), 64'd0);
      a.crd1 = 0; reset = 1'b0;
      tick();                                   // cyc 77
      settle();
      chk("postrst_busy", 64'(a.busy), 64'd0);
      chk("postrst_viol", 64'(a.err_viol), 64'd0);

      // watchdog timeout on the short-budget instance
      wait_to(80);
      b.ready = 1;
      tick();                                   // cyc 81, L0 entered
      b.ready = 0;
      settle();
      chk("to_start0", 64'(b.start0), 64'd1);
      chk("to_busy0",  64'(b.busy), 64'd1);
      wait_to(96);
      settle();
      chk("to_pre_busy", 64'(b.busy), 64'd1);
      chk("to_pre_err",  64'(b.err_timeout), 64'd0);
      tick();                                   // cyc 97, ERR
      b.crd0 = 1; b.csel0 = 3'd5; b.caddr_rd0 = 12'h3FF;
      settle();
      chk("to_err",  64'(b.err_timeout), 64'd1);
      chk("to_busy", 64'(b.busy), 64'd0);
      chk("to_port", 64'({b.crd, b.cwr, b.csel, b.caddr_rd, b.caddr_wr, b.cdata_wr}), 64'd0);
      tick();                                   // cyc 98
      b.crd0 = 0; b.csel0 = '0; b.caddr_rd0 = '0;
      settle();
      chk("to_viol", 64'(b.err_viol), 64'd1);
      chk("to_hold", 64'(b.err_timeout), 64'd1);
      wait_to(100);
      b.ready = 1;
      tick();                                   // cyc 101
      b.ready = 0;
      settle();
      chk("to_restart", 64'(b.start0), 64'd1);
      chk("to_err_clr", 64'({b.err_timeout, b.err_viol}), 64'd0);
      chk("to_rebusy",  64'(b.busy), 64'd1);
      tick();                                   // cyc 102
      settle();
      chk("to_start_once", 64'(b.start0), 64'd0);

      chk("ev_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
